// File: rtl/word_match_engine.sv
// word_match_engine: stores a secret word and scans it per guess, tracking revealed positions.
// Define WME_CASE_FOLD_EN to fold ASCII 'a'-'z' to 'A'-'Z' on load and guess.
module word_match_engine #(
  parameter int ADDR_W = 5,
  parameter int CHAR_W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clear,
  input  logic                ld,
  input  logic [CHAR_W-1:0]   ld_data,
  input  logic                compare,
  input  logic [CHAR_W-1:0]   guess,
  output logic                busy,
  output logic                done,
  output logic                match,
  output logic                repeat_guess,
  output logic [ADDR_W:0]     count,
  output logic [ADDR_W:0]     remain,
  output logic                all_found,
  output logic [ADDR_W:0]     word_len,
  output logic                full,
  output logic [2**ADDR_W-1:0] reveal_mask
);
  localparam int MAX_LEN = 2**ADDR_W;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic [CHAR_W-1:0] store [MAX_LEN];
  logic [CHAR_W-1:0] g;
  logic [ADDR_W-1:0] ptr;
  logic seen, eq, hit, last;
  logic [ADDR_W:0] cnt_nxt;
  function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
`ifdef WME_CASE_FOLD_EN
    return (c >= CHAR_W'(97) && c <= CHAR_W'(122)) ? c - CHAR_W'(32) : c;
`else
    return c;
`endif
  endfunction
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign full      = word_len == (ADDR_W+1)'(MAX_LEN);
  assign all_found = word_len != '0 && remain == '0;
  // an empty word must never compare against stale store contents
  assign eq      = word_len != '0 && store[ptr] == g;
  assign hit     = eq && !reveal_mask[ptr];
  assign last    = word_len == '0 || {1'b0, ptr} + (ADDR_W+1)'(1) == word_len;
  assign cnt_nxt = count + (ADDR_W+1)'(hit);
  always_ff @(posedge clk)
    if (state == IDLE && ld && !full && !clear) store[word_len[ADDR_W-1:0]] <= fold(ld_data);
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state        <= IDLE;
      word_len     <= '0;
      remain       <= '0;
      count        <= '0;
      reveal_mask  <= '0;
      match        <= 1'b0;
      repeat_guess <= 1'b0;
      ptr          <= '0;
      seen         <= 1'b0;
      g            <= '0;
    end else if (clear) begin
      state        <= IDLE;
      word_len     <= '0;
      remain       <= '0;
      count        <= '0;
      reveal_mask  <= '0;
      match        <= 1'b0;
      repeat_guess <= 1'b0;
      ptr          <= '0;
      seen         <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (ld) begin
            if (!full) begin
              word_len <= word_len + 1'b1;
              remain   <= remain + 1'b1;
            end
          end else if (compare) begin
            g            <= fold(guess);
            count        <= '0;
            seen         <= 1'b0;
            ptr          <= '0;
            match        <= 1'b0;
            repeat_guess <= 1'b0;
            state        <= SCAN;
          end
        SCAN: begin
          if (hit) begin
            reveal_mask[ptr] <= 1'b1;
            remain           <= remain - 1'b1;
          end
          count <= cnt_nxt;
          seen  <= seen | (eq && reveal_mask[ptr]);
          ptr   <= ptr + 1'b1;
          if (last) begin
            match        <= cnt_nxt != '0;
            repeat_guess <= cnt_nxt == '0 && (seen | (eq && reveal_mask[ptr]));
            state        <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_word_match_engine.sv
// tb_word_match_engine: scoreboard bench; driver queues expected scan results, monitor checks each done pulse.
module tb_word_match_engine;
  logic clk = 0, resetn = 1, clear = 0, ld = 0, compare = 0;
  logic [7:0] ld_data = 0, guess = 0;
  logic busy, done, match, repeat_guess, all_found, full;
  logic [5:0] count, remain, word_len;
  logic [31:0] reveal_mask;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    int cyc;
    logic m, r, af;
    logic [5:0] c, rem;
    logic [31:0] mask;
  } exp_t;
  exp_t q[$];

  word_match_engine dut (
    .clk(clk), .resetn(resetn), .clear(clear), .ld(ld), .ld_data(ld_data),
    .compare(compare), .guess(guess), .busy(busy), .done(done), .match(match),
    .repeat_guess(repeat_guess), .count(count), .remain(remain), .all_found(all_found),
    .word_len(word_len), .full(full), .reveal_mask(reveal_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("match", match, e.m);
        chk("repeat_guess", repeat_guess, e.r);
        chk("count", count, e.c);
        chk("remain", remain, e.rem);
        chk("reveal_mask", reveal_mask, e.mask);
        chk("all_found", all_found, e.af);
      end
    end
  end

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) begin
      ld = 1; ld_data = s[i];
      @(negedge clk);
    end
    ld = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  task automatic cmp(input logic [7:0] ch, input int wl, input logic m, input logic r,
                     input int c, input int rem, input logic [31:0] mask, input logic af);
    exp_t e;
    e.cyc = cyc + 1 + (wl == 0 ? 1 : wl);
    e.m = m; e.r = r; e.af = af; e.c = 6'(c); e.rem = 6'(rem); e.mask = mask;
    q.push_back(e);
    compare = 1; guess = ch;
    @(negedge clk);
    compare = 0;
    for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    chk("scan_timeout", busy, 0);
    chk("done_seen", 64'(q.size()), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, match, repeat_guess, count, remain, all_found,
                          word_len, full, reveal_mask}, 0);
    resetn = 0;
    @(negedge clk);
    load("HELLO");
    chk("load_word_len", word_len, 5);
    chk("load_remain", remain, 5);
    chk("load_mask", reveal_mask, 0);
    chk("load_full", full, 0);
    cmp("L", 5, 1, 0, 2, 3, 32'b01100, 0);
    cmp("L", 5, 0, 1, 0, 3, 32'b01100, 0);
    cmp("Z", 5, 0, 0, 0, 3, 32'b01100, 0);
    cmp("H", 5, 1, 0, 1, 2, 32'b01101, 0);
    cmp("E", 5, 1, 0, 1, 1, 32'b01111, 0);
    cmp("O", 5, 1, 0, 1, 0, 32'b11111, 1);
    do_clear();
    chk("clear_state", {word_len, remain, count, reveal_mask, match, repeat_guess, all_found}, 0);
    cmp("A", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 33; i++) begin
      ld = 1; ld_data = (i == 5 || i == 20 || i == 32) ? "Q" : "B";
      @(negedge clk);
    end
    ld = 0;
    chk("full_word_len", word_len, 32);
    chk("full_flag", full, 1);
    chk("full_remain", remain, 32);
    cmp("Q", 32, 1, 0, 2, 30, 32'h0010_0020, 0);
    cmp("B", 32, 1, 0, 30, 0, 32'hFFFF_FFFF, 1);
    do_clear();
    load("CAT");
`ifdef WME_CASE_FOLD_EN
    cmp("a", 3, 1, 0, 1, 2, 32'b010, 0);
`else
    cmp("a", 3, 0, 0, 0, 3, 32'b000, 0);
`endif
    ld = 1; ld_data = "S"; compare = 1; guess = "C";
    @(negedge clk);
    ld = 0; compare = 0;
    chk("ld_cmp_busy", busy, 0);
    chk("ld_cmp_word_len", word_len, 4);
    do_clear();
    load("HELLO");
    compare = 1; guess = "L";
    @(negedge clk);
    compare = 0;
    repeat (2) @(negedge clk);
    chk("mid_scan_busy", busy, 1);
    do_clear();
    chk("abort_busy", busy, 0);
    chk("abort_state", {word_len, remain, count, reveal_mask, match, repeat_guess}, 0);
    repeat (10) @(negedge clk);
    chk("abort_queue", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
